fifo_poll_arbiter: RTL

FIFO_POLL_ARBITER -- requirements
Module: fifo_poll_arbiter

---
 rtl/fifo_poll_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/fifo_poll_arbiter.sv
// fifo_poll_arbiter: burst poller over three DCFIFO read sides (round-robin; POLL_FIXED_PRIORITY_EN selects fixed ch0>ch1>ch2)
module fifo_poll_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic        rdclk,
    input  logic        rst,
    input  logic [2:0]  rdempty,
    input  logic [63:0] q0,
    input  logic [63:0] q1,
    input  logic [63:0] q2,
    output logic [2:0]  rdreq,
    output logic [2:0]  access,
    output logic [63:0] q_out
);
    typedef enum logic {IDLE, READ} state_t;
    localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
    state_t state, state_nxt;
    logic [1:0] grant, grant_nxt, rr_ptr, rr_ptr_nxt, start, c1, c2, pick;
    logic [7:0] cnt, cnt_nxt;
    logic done;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef POLL_FIXED_PRIORITY_EN
    assign start = 2'd0;
`else
    assign start = rr_ptr;
`endif
    assign c1 = wrap_inc(start);
    assign c2 = wrap_inc(c1);
    assign pick = !rdempty[start] ? start : !rdempty[c1] ? c1 : c2;
    assign done = rdempty[grant] || (cnt == LAST);

    // arbitration in IDLE, burst strobe and exit conditions in READ
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt = cnt;
        rr_ptr_nxt = rr_ptr;
        rdreq = 3'b000;
        if (state == IDLE) begin
            if (!(&rdempty)) begin
                grant_nxt = pick;
                cnt_nxt = 8'd0;
                state_nxt = READ;
            end
        end else begin
            rdreq[grant] = ~rdempty[grant];
            if (done) begin
                state_nxt = IDLE;
                rr_ptr_nxt = wrap_inc(grant);
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
        end
    end

    // state registers; access is rdreq delayed to match the FIFO read latency
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= 2'd0;
            cnt <= 8'd0;
            rr_ptr <= 2'd0;
            access <= 3'b000;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            cnt <= cnt_nxt;
            rr_ptr <= rr_ptr_nxt;
            access <= rdreq;
        end
    end

    assign q_out = (access == 3'b001) ? q0 :
                   (access == 3'b010) ? q1 :
                   (access == 3'b100) ? q2 : 64'd0;
endmodule
